// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time front end for the processor. Decodes a 32-bit
//               valid/ready word stream into instruction/data memory writes,
//               holds the processor in reset while loading, releases it with
//               a terminating PC and times the run until the finished flag.
// Revision    : 1.0 - initial release
// ============================================================================
// `final` is a reserved word in SystemVerilog, so the terminating-PC port is
// named final_pc.
module program_loader (
  input  logic        clk,
  input  logic        reset,        // active-low, asynchronous assert
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        proc_reset,
  output logic [31:0] final_pc,
  input  logic        signal,
  output logic        run,
  output logic        done,
  output logic        err,
  output logic [31:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  localparam logic [1:0] CMD_LOAD_I = 2'b00;
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_START  = 2'b10;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  remaining_q, remaining_d;
  logic        wr_en_q, wr_en_d;
  logic        wr_sel_q, wr_sel_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        proc_reset_q, proc_reset_d;
  logic [31:0] final_q, final_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        xfer;

  // Ready depends only on state and reset so it never loops back through in_valid.
  assign in_ready = reset & ((state_q == S_IDLE) | (state_q == S_PAYLOAD) | (state_q == S_DONE));
  assign xfer     = in_valid & in_ready;

  // Next-state and next-output decode for header, payload and run phases.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    proc_reset_d = proc_reset_q;
    final_d      = final_q;
    run_d        = run_q;
    done_d       = done_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      // DONE decodes headers exactly like IDLE; a START here re-runs without reloading.
      S_IDLE, S_DONE: begin
        if (xfer) begin
          case (in_data[31:30])
            CMD_LOAD_I, CMD_LOAD_D: begin
              wr_sel_d     = in_data[30];
              addr_d       = in_data[15:8];
              remaining_d  = {1'b0, in_data[23:16]} + 9'd1;
              proc_reset_d = 1'b1;
              done_d       = 1'b0;
              state_d      = S_PAYLOAD;
            end
            CMD_START: begin
              final_d      = {24'b0, in_data[7:0]};
              proc_reset_d = 1'b0;
              run_d        = 1'b1;
              done_d       = 1'b0;
              run_cycles_d = 32'd0;
              state_d      = S_RUN;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = in_data;
          addr_d      = addr_q + 8'd1;   // wraps 255 -> 0 inside a segment
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        // The edge that samples signal still counts toward the run length.
        if (run_cycles_q != 32'hFFFF_FFFF) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
        if (signal) begin
          run_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        // ERR: everything holds until reset.
        state_d = S_ERR;
      end
    endcase
  end

  // State and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 8'd0;
      remaining_q  <= 9'd0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 32'd0;
      proc_reset_q <= 1'b1;
      final_q      <= 32'd0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      proc_reset_q <= proc_reset_d;
      final_q      <= final_d;
      run_q        <= run_d;
      done_q       <= done_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign proc_reset = proc_reset_q;
  assign final_pc   = final_q;
  assign run        = run_q;
  assign done       = done_q;
  assign err        = err_q;
  assign run_cycles = run_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Expected memory writes
//               are queued as stimulus is driven and popped by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        wr_en;
  logic        wr_sel;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        proc_reset;
  logic [31:0] final_pc;
  logic        signal = 1'b0;
  logic        run;
  logic        done;
  logic        err;
  logic [31:0] run_cycles;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_count = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc = -1;
  int stall_cnt = 0;

  // expected write: {sel, addr, data}
  logic [40:0] exp_q[$];

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .proc_reset (proc_reset),
    .final_pc   (final_pc),
    .signal     (signal),
    .run        (run),
    .done       (done),
    .err        (err),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {23'd0, wr_sel, wr_addr, wr_data}, 64'h0);
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        check("wr_sel_addr_data", {23'd0, wr_sel, wr_addr, wr_data}, {23'd0, e});
      end
    end
  end

  task automatic clr_wr_stats();
    wr_count = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    stall_cnt = 0;
  endtask

  // Present one word and hold until accepted; returns 1 time unit after the transfer edge.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic sel, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({sel, a, d});
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"},   {63'd0, in_ready},   64'd0);
    check({pfx, "_wr_en"},      {63'd0, wr_en},      64'd0);
    check({pfx, "_wr_sel"},     {63'd0, wr_sel},     64'd0);
    check({pfx, "_wr_addr"},    {56'd0, wr_addr},    64'd0);
    check({pfx, "_wr_data"},    {32'd0, wr_data},    64'd0);
    check({pfx, "_proc_reset"}, {63'd0, proc_reset}, 64'd1);
    check({pfx, "_final"},      {32'd0, final_pc},   64'd0);
    check({pfx, "_run"},        {63'd0, run},        64'd0);
    check({pfx, "_done"},       {63'd0, done},       64'd0);
    check({pfx, "_err"},        {63'd0, err},        64'd0);
    check({pfx, "_run_cycles"}, {32'd0, run_cycles}, 64'd0);
  endtask

  initial begin
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    #1;
    check("rst_release_ready", {63'd0, in_ready}, 64'd1);

    // ---- LOAD_I base 0x00, 4 words back-to-back ----
    clr_wr_stats();
    send(32'h0003_0000);
    check("loadi_proc_reset", {63'd0, proc_reset}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      push_wr(1'b0, 8'(i), 32'hA000_0000 + 32'(i));
      send(32'hA000_0000 + 32'(i));
    end
    idle_cycles(3);
    check("loadi_stalls", 64'(stall_cnt), 64'd0);
    check("loadi_count", 64'(wr_count), 64'd4);
    check("loadi_consecutive", 64'(last_wr_cyc - first_wr_cyc), 64'd3);

    // ---- LOAD_D base 0xFE, gapped valid, address wrap ----
    clr_wr_stats();
    send(32'h4003_FE00);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(i);
      push_wr(1'b1, a, 32'hD000_0000 + 32'(i * 17));
      send(32'hD000_0000 + 32'(i * 17));
      idle_cycles(2);
    end
    idle_cycles(2);
    check("loadd_count", 64'(wr_count), 64'd4);
    check("loadd_proc_reset", {63'd0, proc_reset}, 64'd1);

    // ---- START final=0x10, signal 20 cycles later ----
    clr_wr_stats();
    send(32'h8000_0010);
    in_valid = 1'b0;
    check("start_proc_reset", {63'd0, proc_reset}, 64'd0);
    check("start_run",        {63'd0, run},        64'd1);
    check("start_final",      {32'd0, final_pc},   64'h10);
    check("start_cycles0",    {32'd0, run_cycles}, 64'd0);
    check("start_ready",      {63'd0, in_ready},   64'd0);
    repeat (19) @(posedge clk);
    #1;
    signal = 1'b1;
    @(posedge clk);
    #1;
    signal = 1'b0;
    check("run1_done",   {63'd0, done},       64'd1);
    check("run1_run",    {63'd0, run},        64'd0);
    check("run1_cycles", {32'd0, run_cycles}, 64'd20);
    idle_cycles(3);
    check("run1_done_sticky",   {63'd0, done},       64'd1);
    check("run1_cycles_frozen", {32'd0, run_cycles}, 64'd20);
    check("run1_ready",         {63'd0, in_ready},   64'd1);

    // ---- second START from DONE, no reload ----
    send(32'h8000_0022);
    in_valid = 1'b0;
    check("rerun_done",   {63'd0, done},       64'd0);
    check("rerun_run",    {63'd0, run},        64'd1);
    check("rerun_cycles", {32'd0, run_cycles}, 64'd0);
    check("rerun_final",  {32'd0, final_pc},   64'h22);
    repeat (4) @(posedge clk);
    #1;
    signal = 1'b1;
    @(posedge clk);
    #1;
    signal = 1'b0;
    check("rerun_cycles_end", {32'd0, run_cycles}, 64'd5);
    check("rerun_done_end",   {63'd0, done},       64'd1);
    check("rerun_no_writes",  64'(wr_count),       64'd0);

    // ---- reserved command ----
    send(32'hC000_0000);
    in_valid = 1'b0;
    check("rsv_err",   {63'd0, err},      64'd1);
    check("rsv_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rsv_err_hold",   {63'd0, err},      64'd1);
    check("rsv_ready_hold", {63'd0, in_ready}, 64'd0);
    check("rsv_done_hold",  {63'd0, done},     64'd1);
    check("rsv_no_writes",  64'(wr_count),     64'd0);

    // ---- reset clears ERR; then reset aborts a payload mid-way ----
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clr_wr_stats();
    send(32'h0003_4000);
    push_wr(1'b0, 8'h40, 32'h1111_0000);
    send(32'h1111_0000);
    push_wr(1'b0, 8'h41, 32'h1111_0001);
    send(32'h1111_0001);
    in_data = 32'h1111_0002;   // third word presented, reset hits before it transfers
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midrst_writes", 64'(wr_count), 64'd2);

    // ---- fresh LOAD_I after reset ----
    clr_wr_stats();
    send(32'h0001_2000);
    push_wr(1'b0, 8'h20, 32'h5555_AAAA);
    send(32'h5555_AAAA);
    push_wr(1'b0, 8'h21, 32'h1234_5678);
    send(32'h1234_5678);
    idle_cycles(3);
    check("reload_count", 64'(wr_count), 64'd2);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time front end that sits directly upstream of `processor`. It accepts a 32-bit word stream from the bench or host over a valid/ready handshake and decodes header commands. It writes payload words into the 256x32 instruction memory or the 256x32 data memory, holds the processor in reset while loading, then releases it with the terminating PC on `final`. It watches `signal` to report completion and the run length in cycles.

## Interface
- No parameters. Memory depth is fixed at 256 words and address width at 8 bits.
- `clk`  in  1  System clock; all state updates on its rising edge.
- `reset`  in  1  Asynchronous reset, active-low: 0 = in reset. Released synchronously to `clk` by the environment.
- `in_valid`  in  1  A stream word is present on `in_data`.
- `in_data`  in  32  Stream word: a header or a payload word.
- `in_ready`  out  1  The loader accepts `in_data` this cycle. Transfer = `in_valid & in_ready` at a rising edge.
- `wr_en`  out  1  One-cycle memory write strobe.
- `wr_sel`  out  1  Write target: 0 = instruction memory, 1 = data memory.
- `wr_addr`  out  8  Write word address.
- `wr_data`  out  32  Write data.
- `proc_reset`  out  1  Processor reset, active-high. Drives `processor.reset`.
- `final`  out  32  Terminating PC value. Drives `processor.final`.
- `signal`  in  1  Program-finished flag from `processor`.
- `run`  out  1  The processor is executing.
- `done`  out  1  The program finished. Sticky.
- `err`  out  1  A reserved command was received. Sticky until reset.
- `run_cycles`  out  32  Number of cycles spent in RUN. Saturates at 0xFFFF_FFFF.

## Operation
- Header fields:
  - [31:30] cmd
  - [23:16] len-1, giving 1..256 words
  - [15:8] base address
  - [7:0] final PC (START only); other bits ignored.
- Commands: 00 LOAD_I, 01 LOAD_D, 10 START, 11 reserved.
- State IDLE: `in_ready`=1.
  - On a header transfer with LOAD_I or LOAD_D: latch `wr_sel`=cmd[0], addr=base, remaining=len-1+1 (9-bit). Go to PAYLOAD. `proc_reset` is set to 1.
  - On START: `final`={24'b0, hdr[7:0]}, `proc_reset`=0, `run`=1, `done`=0, `run_cycles`=0. Go to RUN.
  - On reserved: `err`=1. Go to ERR.
- State PAYLOAD: `in_ready`=1. Each transfer writes the word: `wr_en`=1, `wr_addr`=addr, `wr_data`=word. Then addr increments mod 256 and remaining decrements.
  - The transfer where remaining reaches 0 returns the FSM to IDLE.
  - Address wraps 255 -> 0 within a segment. The loader does not check overlap; a later write overwrites an earlier one.
- State RUN: `in_ready`=0. `run_cycles` increments every cycle, saturating.
  - When `signal`=1 is sampled: `run`=0 and `done`=1. Go to DONE.
  - `proc_reset` stays 0, so the processor holds its state for inspection.
- State DONE: `in_ready`=1, behaving as IDLE for header decoding.
  - A LOAD header clears `done`, reasserts `proc_reset`, and enters PAYLOAD.
  - A START header re-runs the processor without reloading memory.
- State ERR: `in_ready`=0. All outputs hold. Exit only via reset.
- START issued with no prior LOAD is legal. The processor runs whatever the memories hold.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - state=IDLE, `in_ready`=0 while `reset`=0, `wr_en`=0, `wr_sel`=0, `wr_addr`=0, `wr_data`=0
  - `proc_reset`=1, `final`=0, `run`=0, `done`=0, `err`=0, `run_cycles`=0
- `in_ready` is combinational from state and `reset` only. It never depends on `in_valid`.
- Write latency: a payload transfer at edge N produces `wr_en`=1 with its addr and data during cycle N+1. `wr_en` is 0 in all other cycles.
- Back-to-back payload words give one write per cycle. A deasserted `in_valid` inserts bubbles without losing position.
- A START transfer at edge N gives `proc_reset`=0, `run`=1, and valid `final` in cycle N+1. `run_cycles` first increments at edge N+1.
- `signal` is sampled at edge M in RUN. In cycle M+1: `done`=1, `run`=0, and `run_cycles` is frozen at the count including edge M.
- The last payload write (cycle N+1) and the next header acceptance (edge N+1) may overlap.
- Reset asserted mid-PAYLOAD or mid-RUN aborts immediately to the reset values. Partially written memory contents are not cleared.

## Test plan
- Reset then LOAD_I with base=0x00, len-1=3, words A0..A3 sent back-to-back -> writes at addr 0..3 with sel=0 on 4 consecutive cycles; `in_ready` stays 1.
- LOAD_D with base=0xFE, len-1=3 and `in_valid` gapped -> writes at addr FE, FF, 00, 01 with sel=1; no extra `wr_en` pulses during gaps.
- START with final=0x10, `signal` driven high 20 cycles later -> `proc_reset` falls 1 cycle after the handshake; `final`=0x10; `done`=1 and `run_cycles`=20 (±0, checked exactly).
- Header 0xC0000000 (reserved) -> `err`=1, `in_ready`=0 permanently; further `in_valid` is ignored until reset.
- Reset pulsed low during the 3rd payload word -> all outputs return to their reset values asynchronously; after release, a new LOAD_I is accepted normally.
- After DONE, a second START -> `done` clears, `run_cycles` restarts from 0, and memories receive no writes.
